// File: rtl/riscv_base_alu_issue.sv
// riscv_base_alu_issue
//   Execute-issue stage feeding riscv_base_alu. Decodes RV32I OP, OP-IMM, LUI
//   and AUIPC, selects ALU operands (register / immediate / PC), forwards
//   writeback data into register operands, and holds the result in a single
//   ID/EX entry behind a valid/ready handshake.
//
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   in_valid_i / in_ready_o        upstream handshake for instr_i / pc_i
//   instr_i, pc_i                  instruction word and its PC
//   rs1_addr_o, rs2_addr_o         combinational regfile read addresses
//   rs1_data_i, rs2_data_i         same-cycle regfile read data
//   wb_we_i, wb_rd_i, wb_data_i    writeback port (forwarding source)
//   flush_i                        kill held and incoming instruction
//   out_valid_o / out_ready_i      downstream handshake for the ID/EX entry
//   alu_op_o, alu_a_o, alu_b_o     registered ALU controls and operands
//   rd_o, rd_we_o, illegal_o, pc_o entry destination, write enable, flags, PC

module riscv_base_alu_issue #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [3:0]      alu_op_o,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o,
    output logic [4:0]      rd_o,
    output logic            rd_we_o,
    output logic            illegal_o,
    output logic [XLEN-1:0] pc_o
);

    // ALU operation codes shared with riscv_base_alu.
    typedef enum logic [3:0] {
        ALU_SHIFT_LEFT             = 4'b0001,
        ALU_SHIFT_RIGHT_LOGICAL    = 4'b0010,
        ALU_SHIFT_RIGHT_ARITHMETIC = 4'b0011,
        ALU_ADD                    = 4'b0100,
        ALU_SUB                    = 4'b0110,
        ALU_AND                    = 4'b0111,
        ALU_OR                     = 4'b1000,
        ALU_XOR                    = 4'b1001,
        ALU_LESS_THAN              = 4'b1010,
        ALU_LESS_THAN_UNSIGNED     = 4'b1011
    } alu_op_e;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111
    } opcode_e;

    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    alu_op_e         dec_op;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic            dec_a_reg;
    logic            dec_b_reg;
    logic            dec_illegal;

    logic            valid_q;
    alu_op_e         op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [4:0]      rd_q;
    logic            rd_we_q;
    logic            illegal_q;
    logic [XLEN-1:0] pc_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic            a_reg_q;
    logic            b_reg_q;

    logic            accept;
    logic            drain;
    logic            wb_live;

    assign funct7     = instr_i[31:25];
    assign funct3     = instr_i[14:12];
    assign rs1_addr_o = instr_i[19:15];
    assign rs2_addr_o = instr_i[24:20];
    assign imm_i      = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    assign imm_u      = {instr_i[31:12], 12'b0};
    assign shamt      = {{(XLEN-5){1'b0}}, instr_i[24:20]};

    // x0 is never a forwarding target.
    assign wb_live = wb_we_i && (wb_rd_i != 5'd0);
    assign rs1_fwd = (wb_live && wb_rd_i == rs1_addr_o) ? wb_data_i : rs1_data_i;
    assign rs2_fwd = (wb_live && wb_rd_i == rs2_addr_o) ? wb_data_i : rs2_data_i;

    assign in_ready_o = !valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o && !flush_i;
    assign drain      = valid_q && out_ready_i && !accept;

    always_comb begin
        dec_op      = ALU_ADD;
        dec_a       = '0;
        dec_b       = '0;
        dec_a_reg   = 1'b0;
        dec_b_reg   = 1'b0;
        dec_illegal = 1'b0;
        case (instr_i[6:0])
            OPC_OP: begin
                dec_a     = rs1_fwd;
                dec_b     = rs2_fwd;
                dec_a_reg = 1'b1;
                dec_b_reg = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: dec_op = ALU_ADD;
                    {7'h20, 3'b000}: dec_op = ALU_SUB;
                    {7'h00, 3'b001}: dec_op = ALU_SHIFT_LEFT;
                    {7'h00, 3'b010}: dec_op = ALU_LESS_THAN;
                    {7'h00, 3'b011}: dec_op = ALU_LESS_THAN_UNSIGNED;
                    {7'h00, 3'b100}: dec_op = ALU_XOR;
                    {7'h00, 3'b101}: dec_op = ALU_SHIFT_RIGHT_LOGICAL;
                    {7'h20, 3'b101}: dec_op = ALU_SHIFT_RIGHT_ARITHMETIC;
                    {7'h00, 3'b110}: dec_op = ALU_OR;
                    {7'h00, 3'b111}: dec_op = ALU_AND;
                    default:         dec_illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                dec_a     = rs1_fwd;
                dec_a_reg = 1'b1;
                dec_b     = imm_i;
                case (funct3)
                    3'b000: dec_op = ALU_ADD;
                    3'b010: dec_op = ALU_LESS_THAN;
                    3'b011: dec_op = ALU_LESS_THAN_UNSIGNED;
                    3'b100: dec_op = ALU_XOR;
                    3'b110: dec_op = ALU_OR;
                    3'b111: dec_op = ALU_AND;
                    3'b001: begin
                        dec_b  = shamt;
                        dec_op = ALU_SHIFT_LEFT;
                        if (funct7 != 7'h00) dec_illegal = 1'b1;
                    end
                    default: begin
                        dec_b = shamt;
                        if (funct7 == 7'h00)      dec_op = ALU_SHIFT_RIGHT_LOGICAL;
                        else if (funct7 == 7'h20) dec_op = ALU_SHIFT_RIGHT_ARITHMETIC;
                        else                      dec_illegal = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                dec_b = imm_u;
            end
            OPC_AUIPC: begin
                dec_a = pc_i;
                dec_b = imm_u;
            end
            default: dec_illegal = 1'b1;
        endcase
        // Every illegal encoding collapses to a harmless ADD 0,0 with no
        // register tracking, so hold-update never touches it.
        if (dec_illegal) begin
            dec_op    = ALU_ADD;
            dec_a     = '0;
            dec_b     = '0;
            dec_a_reg = 1'b0;
            dec_b_reg = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            op_q      <= ALU_ADD;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            rd_we_q   <= 1'b0;
            illegal_q <= 1'b0;
            pc_q      <= RESET_PC;
            rs1_q     <= '0;
            rs2_q     <= '0;
            a_reg_q   <= 1'b0;
            b_reg_q   <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q   <= 1'b1;
            op_q      <= dec_op;
            a_q       <= dec_a;
            b_q       <= dec_b;
            rd_q      <= instr_i[11:7];
            rd_we_q   <= !dec_illegal && (instr_i[11:7] != 5'd0);
            illegal_q <= dec_illegal;
            pc_q      <= pc_i;
            rs1_q     <= rs1_addr_o;
            rs2_q     <= rs2_addr_o;
            a_reg_q   <= dec_a_reg;
            b_reg_q   <= dec_b_reg;
        end else if (drain) begin
            valid_q <= 1'b0;
        end else if (valid_q) begin
            // Stalled entry: keep register operands coherent with writeback.
            if (a_reg_q && wb_live && wb_rd_i == rs1_q) a_q <= wb_data_i;
            if (b_reg_q && wb_live && wb_rd_i == rs2_q) b_q <= wb_data_i;
        end
    end

    assign out_valid_o = valid_q;
    assign alu_op_o    = op_q;
    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign rd_o        = rd_q;
    assign rd_we_o     = rd_we_q;
    assign illegal_o   = illegal_q;
    assign pc_o        = pc_q;

endmodule

// File: doc/riscv_base_alu_issue.md
Name: riscv_base_alu_issue

Overview:
Execute-issue stage directly upstream of riscv_base_alu. It decodes RV32I OP, OP-IMM, LUI and AUIPC instructions and selects ALU operands (register, immediate or PC). Operands are forwarded from writeback, and the result is held in a single-entry ID/EX register with a valid/ready handshake. The registered alu_op_o, alu_a_o and alu_b_o drive the ALU's alu_op_i, alu_a_i and alu_b_i directly.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
RESET_PC, 32'h0, reset value of pc_o.

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous, active-high reset
in_valid_i  input  1  instr_i/pc_i valid
in_ready_o  output  1  stage can accept this cycle
instr_i  input  32  instruction word
pc_i  input  32  instruction PC
rs1_addr_o  output  5  instr_i[19:15], combinational, to regfile read port A
rs2_addr_o  output  5  instr_i[24:20], combinational, to regfile read port B
rs1_data_i  input  32  regfile read data A, same cycle
rs2_data_i  input  32  regfile read data B, same cycle
wb_we_i  input  1  writeback write enable
wb_rd_i  input  5  writeback destination
wb_data_i  input  32  writeback data
flush_i  input  1  kill held and incoming instruction
out_valid_o  output  1  ID/EX entry valid
out_ready_i  input  1  downstream consumes entry
alu_op_o  output  4  `ALU_* code from riscv_base_defines.v
alu_a_o  output  32  ALU operand A
alu_b_o  output  32  ALU operand B
rd_o  output  5  destination register
rd_we_o  output  1  entry writes rd
illegal_o  output  1  entry is an unsupported encoding
pc_o  output  32  entry PC

Behaviour:
- Reset (rst_i high at edge): out_valid_o=0, alu_op_o=`ALU_ADD, alu_a_o=alu_b_o=0, rd_o=0, rd_we_o=0, illegal_o=0, pc_o=RESET_PC. rst_i overrides flush_i and all other inputs.
- in_ready_o = !out_valid_o || out_ready_i. It is purely combinational and is also 1 while flush_i is high.
- Accept happens when in_valid_i && in_ready_o && !flush_i. The entry loads at that edge, so latency is 1 cycle.
- Drain happens when out_valid_o && out_ready_i and there is no accept. out_valid_o goes to 0 at the next edge.
- flush_i=1: out_valid_o goes to 0 at the next edge and the incoming instruction is discarded. Data fields hold their values and are don't-care.
- Decode, keyed on opcode instr[6:0]:
  - 0110011 (OP): a=rs1, b=rs2. funct3/funct7 map as 000/00 ADD, 000/20 SUB, 001/00 SHIFT_LEFT, 010/00 LESS_THAN, 011/00 LESS_THAN_UNSIGNED, 100/00 XOR, 101/00 SHIFT_RIGHT_LOGICAL, 101/20 SHIFT_RIGHT_ARITHMETIC, 110/00 OR, 111/00 AND. Any other funct7 is illegal.
  - 0010011 (OP-IMM): a=rs1, b=sign-extended I-immediate. For shifts, b={27'b0,instr[24:20]} and funct7 must be 00 (or 20 for SRAI), otherwise illegal. SUB does not exist for immediates.
  - 0110111 (LUI): a=0, b={instr[31:12],12'b0}, op ADD.
  - 0010111 (AUIPC): a=pc_i, b={instr[31:12],12'b0}, op ADD.
  - Any other opcode: illegal_o=1, rd_we_o=0, op ADD, a=b=0.
- rd_o=instr[11:7]. rd_we_o = legal && rd_o!=0.
- Forward at accept: if wb_we_i && wb_rd_i!=0 && wb_rd_i==rs1, the register-sourced operand A uses wb_data_i instead of rs1_data_i. The same rule applies to operand B with rs2. x0 is never forwarded.
- Hold-update while out_valid_o && !out_ready_i:
  - The entry keeps rs1/rs2 indices and a "from register" flag per operand.
  - A matching writeback (same rules as forward-at-accept) replaces that operand at the next edge.
  - Immediate and PC operands are never modified.
- A simultaneous drain and accept replaces the entry with no bubble, and out_valid_o stays 1.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1_data=5, rs2_data=3, no wb -> next cycle out_valid_o=1, alu_op_o=`ALU_ADD, a=5, b=3, rd_o=3, rd_we_o=1.
- SRAI x5,x6,4 (0x40435293), rs1_data=0x80000000 -> alu_op_o=`ALU_SHIFT_RIGHT_ARITHMETIC, a=0x80000000, b=4. Then LUI x7,0x12345 (0x123453B7) -> a=0, b=0x12345000. Then AUIPC x1,1 (0x00001097) with pc_i=0x100 -> a=0x100, b=0x1000.
- SUB x3,x1,x2 (0x402081B3) with rs1_data=8, wb_we_i=1, wb_rd_i=1, wb_data_i=0x64 -> a=0x64, b=rs2_data. Repeat with wb_rd_i=0 -> a=8.
- Back-pressure:
  - Hold out_ready_i=0 with an ADD x3,x1,x2 entry valid, then drive wb x2=0x10 -> alu_b_o=0x10 next cycle, in_ready_o=0, a second in_valid_i is not accepted.
  - Raise out_ready_i with a new instr valid -> back-to-back replacement, out_valid_o stays 1.
- 0xFFFFFFFF -> illegal_o=1, rd_we_o=0. 0x00000013 (ADDI x0) -> illegal_o=0, rd_we_o=0. OP with funct7=0x01 -> illegal_o=1.
- Reset and flush:
  - flush_i with valid entry and incoming instr -> out_valid_o=0 next cycle.
  - rst_i mid-stall -> all outputs reach reset values at the next edge, pc_o=RESET_PC.
